// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and sizing for the sequential multiplier
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int W      = 4;
    localparam int N_ITER = 4;

    localparam logic [1:0] CNT_LAST = 2'(N_ITER - 1);

endpackage

// File: rtl/somador.sv
// somador: 4-bit ripple-carry adder with carry-out as the fifth sum bit
module somador
    import mult_pkg::*;
(
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W:0]   s_o
);

    logic [W:0] c;

    assign c[0]   = 1'b0;
    assign s_o[W] = c[W];

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

endmodule

// File: rtl/multiplicador_seq.sv
// multiplicador_seq: 4x4 unsigned shift-add multiplier with valid/ready handshakes
module multiplicador_seq
    import mult_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_valid,
    output logic           start_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           result_valid,
    input  logic           result_ready,
    output logic [2*W-1:0] product,
    output logic           busy
);

    state_t     state_q;
    logic [W-1:0] m_q;
    logic [W-1:0] q_q;
    logic [W-1:0] h_q;
    logic [1:0]   cnt_q;
    logic [W-1:0] addend;
    logic [W:0]   sum;

    // Add the multiplicand only when the current multiplier bit is set
    assign addend = q_q[0] ? m_q : '0;

    somador u_somador (
        .a_i (h_q),
        .b_i (addend),
        .s_o (sum)
    );

    // Control FSM and shift-add datapath; the 9-bit {carry,H,Q} shift drops the used Q bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            q_q     <= '0;
            h_q     <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (start_valid) begin
                    m_q     <= a;
                    q_q     <= b;
                    h_q     <= '0;
                    cnt_q   <= '0;
                    state_q <= CALC;
                end
                CALC: begin
                    {h_q, q_q} <= {sum, q_q[W-1:1]};
                    cnt_q      <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_q <= DONE;
                end
                DONE: if (result_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake flags decode straight from the state register
    assign start_ready  = (state_q == IDLE);
    assign result_valid = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign product      = {h_q, q_q};

endmodule

// File: tb/tb_multiplicador_seq.sv
// tb_multiplicador_seq: directed vector table plus handshake, reset-abort and exhaustive sequences
module tb_multiplicador_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_valid;
    logic       start_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       result_valid;
    logic       result_ready;
    logic [7:0] product;
    logic       busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
        int         stall;
    } vec_t;

    vec_t tbl[8];

    multiplicador_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .a            (a),
        .b            (b),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .product      (product),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Starts at a negedge in IDLE and returns at a negedge in IDLE.
    // Operands are forced to F during CALC; with stall>0 start_valid stays high
    // through CALC/DONE and result_ready is withheld for stall cycles.
    task automatic run_op(input logic [3:0] va, input logic [3:0] vb, input logic [7:0] exp, input int stall);
        int n;
        a = va;
        b = vb;
        start_valid = 1'b1;
        chk("start_ready_before", 32'(start_ready), 1);
        @(posedge clk);
        n = 1;
        @(negedge clk);
        if (stall == 0) start_valid = 1'b0;
        while (!result_valid && n < 20) begin
            chk("busy_in_calc", 32'(busy), 1);
            a = 4'hF;
            b = 4'hF;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("latency_edges", 32'(n), 5);
        chk("product", 32'(product), 32'(exp));
        chk("busy_in_done", 32'(busy), 1);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", 32'(result_valid), 1);
            chk("stall_product", 32'(product), 32'(exp));
            chk("stall_start_ready", 32'(start_ready), 0);
        end
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ready = 1'b0;
        start_valid = 1'b0;
        chk("idle_start_ready", 32'(start_ready), 1);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_product_hold", 32'(product), 32'(exp));
    endtask

    initial begin
        tbl[0] = '{4'd3,  4'd5,  8'h0F, 0};
        tbl[1] = '{4'd15, 4'd15, 8'hE1, 0};
        tbl[2] = '{4'd0,  4'd9,  8'h00, 0};
        tbl[3] = '{4'd9,  4'd0,  8'h00, 0};
        tbl[4] = '{4'd1,  4'd1,  8'h01, 0};
        tbl[5] = '{4'd3,  4'd5,  8'h0F, 3};
        tbl[6] = '{4'd6,  4'd7,  8'h2A, 0};
        tbl[7] = '{4'd12, 4'd10, 8'h78, 1};

        rst_n = 1'b0;
        start_valid = 1'b0;
        result_ready = 1'b0;
        a = 4'd0;
        b = 4'd0;
        #1;
        chk("rst_start_ready", 32'(start_ready), 1);
        chk("rst_result_valid", 32'(result_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_product", 32'(product), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_op(tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].stall);

        a = 4'd9;
        b = 4'd9;
        start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_start_ready", 32'(start_ready), 1);
        chk("abort_result_valid", 32'(result_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_product", 32'(product), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'd2, 4'd2, 8'h04, 0);

        result_ready = 1'b1;
        start_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'(i);
            a = v[7:4];
            b = v[3:0];
            chk("b2b_start_ready", 32'(start_ready), 1);
            repeat (5) @(negedge clk);
            chk("b2b_valid", 32'(result_valid), 1);
            chk("b2b_product", 32'(product), 32'(v[7:4]) * 32'(v[3:0]));
            @(negedge clk);
        end
        start_valid = 1'b0;
        result_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
